// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the pc_sequencer block.
// Optional feature macro: PC_SEQ_DELAY_SLOT_EN (see pc_sequencer.sv).
package pc_seq_pkg;

    localparam int PC_W       = 32;
    localparam int JIDX_W     = 26;
    localparam int CNT_W      = 2;
    localparam int WORD_SHIFT = 2;

    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } pc_state_e;

    // Word offset to byte offset; the top WORD_SHIFT bits fall off the end.
    function automatic logic [PC_W-1:0] word_to_byte(input logic [PC_W-1:0] word_off);
        return {word_off[PC_W-WORD_SHIFT-1:0], {WORD_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-address candidates: sequential, branch target, jump target.
// Optional feature macro: none.
module pc_target_calc
    import pc_seq_pkg::*;
(
    input  logic [PC_W-1:0]   pc_i,
    input  logic [PC_W-1:0]   branch_pc4_i,
    input  logic [PC_W-1:0]   branch_offset_i,
    input  logic [JIDX_W-1:0] jump_index_i,
    output logic [PC_W-1:0]   seq_pc_o,
    output logic [PC_W-1:0]   branch_tgt_o,
    output logic [PC_W-1:0]   jump_tgt_o
);

    assign seq_pc_o     = pc_i + PC_INC;
    assign branch_tgt_o = branch_pc4_i + word_to_byte(branch_offset_i);
    // Jump stays inside the current 256 MB region selected by the PC's top nibble.
    assign jump_tgt_o   = {pc_i[PC_W-1:PC_W-4], jump_index_i, {WORD_SHIFT{1'b0}}};

endmodule

// File: rtl/pc_sequencer.sv
// PC register, redirect FSM and flush sequencing for the 6-stage pipeline.
// Optional feature macro: PC_SEQ_DELAY_SLOT_EN (keep branch delay slot, shorter flush).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_W-1:0]     branch_pc4,
    input  logic [PC_W-1:0]     branch_offset,
    input  logic                jump_req,
    input  logic [JIDX_W-1:0]   jump_index,
    output logic [PC_W-1:0]     pc_out,
    output logic                fetch_valid,
    output logic                flush_out,
    output logic                redirect_busy
);

`ifdef PC_SEQ_DELAY_SLOT_EN
    localparam int   FLUSH_LEN = FLUSH_CYCLES - 1;
    localparam logic KEEP_SLOT = 1'b1;
`else
    localparam int   FLUSH_LEN = FLUSH_CYCLES;
    localparam logic KEEP_SLOT = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_RELOAD =
        (FLUSH_LEN > 0) ? CNT_W'(FLUSH_LEN - 1) : {CNT_W{1'b0}};

    pc_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               fv_q, fv_d;
    logic               flush_q, flush_d;

    logic [PC_W-1:0]    seq_pc_s;
    logic [PC_W-1:0]    branch_tgt_s;
    logic [PC_W-1:0]    jump_tgt_s;
    logic [PC_W-1:0]    redir_tgt_s;
    logic               redir_s;

    pc_target_calc u_tgt (
        .pc_i            (pc_q),
        .branch_pc4_i    (branch_pc4),
        .branch_offset_i (branch_offset),
        .jump_index_i    (jump_index),
        .seq_pc_o        (seq_pc_s),
        .branch_tgt_o    (branch_tgt_s),
        .jump_tgt_o      (jump_tgt_s)
    );

    // Branch is the older instruction, so it beats a same-cycle jump; jumps in FLUSH are squashed.
    assign redir_s     = branch_taken | (jump_req & (state_q == ST_RUN));
    assign redir_tgt_s = branch_taken ? branch_tgt_s : jump_tgt_s;

    // Next-state, next-PC and flush/valid sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        fv_d    = fv_q;
        flush_d = flush_q;

        if (redir_s) begin
            pc_d = redir_tgt_s;
            if (FLUSH_LEN > 0) begin
                state_d = ST_FLUSH;
                cnt_d   = CNT_RELOAD;
                flush_d = 1'b1;
                fv_d    = KEEP_SLOT ? fv_q : 1'b0;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (stall) begin
                        pc_d = pc_q;
                    end else if (!fv_q) begin
                        // First fetch after reset issues RESET_PC before advancing.
                        fv_d = 1'b1;
                    end else begin
                        pc_d = seq_pc_s;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d = ST_RUN;
                        flush_d = 1'b0;
                        fv_d    = 1'b1;
                    end else begin
                        cnt_d   = cnt_q - 2'd1;
                        flush_d = 1'b1;
                        fv_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                    flush_d = 1'b0;
                    fv_d    = 1'b0;
                end
            endcase
        end
    end

    // State, counter, PC and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= {CNT_W{1'b0}};
            pc_q    <= RESET_PC;
            fv_q    <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            fv_q    <= fv_d;
            flush_q <= flush_d;
        end
    end

    assign pc_out        = pc_q;
    assign fetch_valid   = fv_q;
    assign flush_out     = flush_q;
    assign redirect_busy = (state_q == ST_FLUSH);

endmodule
